// File: rtl/weight_fetch_sequencer.sv
// Tile-level weight read sequencer: walks a row-major tile one SPRAM read at a time
// and streams the returned words through a small FIFO tagged with row-end/tile-end flags.
module weight_fetch_sequencer #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 16,
    parameter int DIM_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_base,
    input  logic [DIM_WIDTH-1:0]  cmd_rows,
    input  logic [DIM_WIDTH-1:0]  cmd_cols,
    input  logic [ADDR_WIDTH-1:0] cmd_stride,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_re,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_valid,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic                  w_valid,
    input  logic                  w_ready,
    output logic                  w_last_col,
    output logic                  w_last,
    output logic                  busy,
    output logic                  done
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = DATA_WIDTH + 2;
    localparam logic [CNT_W-1:0]     DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [DIM_WIDTH-1:0] DIM_ONE   = DIM_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [DIM_WIDTH-1:0]  rows_q, rows_d;
    logic [DIM_WIDTH-1:0]  cols_q, cols_d;
    logic [DIM_WIDTH-1:0]  r_q, r_d;
    logic [DIM_WIDTH-1:0]  c_q, c_d;
    logic [ADDR_WIDTH-1:0] stride_q, stride_d;
    logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  pending_q, pending_d;
    logic                  pend_last_q, pend_last_d;
    logic                  pend_last_col_q, pend_last_col_d;
    logic                  all_issued_q, all_issued_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [ENTRY_W-1:0]    fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic                  accept;
    logic                  ret;
    logic                  push;
    logic                  pop;
    logic                  issue;
    logic                  slot_free;
    logic                  at_last_col;
    logic                  at_last_row;
    logic [CNT_W-1:0]      count_after;
    logic [ENTRY_W-1:0]    head;
    logic [DIM_WIDTH-1:0]  cur_r, cur_c, cur_rows, cur_cols;
    logic [ADDR_WIDTH-1:0] cur_row_base, cur_stride;

    assign accept      = cmd_valid & cmd_ready_q;
    // A response only counts if a read is actually outstanding.
    assign ret         = pending_q & mem_valid;
    assign push        = ret;
    assign head        = fifo_mem[rd_ptr_q];
    assign w_valid     = (count_q != '0);
    assign pop         = w_valid & w_ready;
    assign count_after = count_q + CNT_W'(push) - CNT_W'(pop);
    assign slot_free   = ~pending_q | mem_valid;

    assign cmd_ready  = cmd_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign mem_addr   = mem_addr_q;
    assign mem_re     = pending_q & ~mem_valid;
    assign w_data     = w_valid ? head[DATA_WIDTH-1:0] : '0;
    assign w_last_col = w_valid & head[DATA_WIDTH];
    assign w_last     = w_valid & head[DATA_WIDTH+1];

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d         = state_q;
        rows_d          = rows_q;
        cols_d          = cols_q;
        r_d             = r_q;
        c_d             = c_q;
        stride_d        = stride_q;
        row_base_d      = row_base_q;
        mem_addr_d      = mem_addr_q;
        pending_d       = pending_q;
        pend_last_d     = pend_last_q;
        pend_last_col_d = pend_last_col_q;
        all_issued_d    = all_issued_q;
        issue           = 1'b0;

        // The first read is issued straight from the descriptor in the accept cycle.
        if (state_q == S_IDLE) begin
            cur_r        = '0;
            cur_c        = '0;
            cur_rows     = cmd_rows;
            cur_cols     = cmd_cols;
            cur_row_base = cmd_base;
            cur_stride   = cmd_stride;
        end else begin
            cur_r        = r_q;
            cur_c        = c_q;
            cur_rows     = rows_q;
            cur_cols     = cols_q;
            cur_row_base = row_base_q;
            cur_stride   = stride_q;
        end
        at_last_col = (cur_c == cur_cols - DIM_ONE);
        at_last_row = (cur_r == cur_rows - DIM_ONE);

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    rows_d       = cmd_rows;
                    cols_d       = cmd_cols;
                    stride_d     = cmd_stride;
                    r_d          = '0;
                    c_d          = '0;
                    row_base_d   = cmd_base;
                    all_issued_d = 1'b0;
                    if ((cmd_rows == '0) || (cmd_cols == '0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                        issue   = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                issue = ~all_issued_q & slot_free & (count_after < DEPTH_CNT);
                if (all_issued_q & ret) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop & head[DATA_WIDTH+1]) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (ret) begin
            pending_d = 1'b0;
        end
        if (issue) begin
            pending_d       = 1'b1;
            mem_addr_d      = cur_row_base + ADDR_WIDTH'(cur_c);
            pend_last_col_d = at_last_col;
            pend_last_d     = at_last_col & at_last_row;
            all_issued_d    = at_last_col & at_last_row;
            if (at_last_col) begin
                c_d        = '0;
                r_d        = cur_r + DIM_ONE;
                row_base_d = cur_row_base + cur_stride;
            end else begin
                c_d        = cur_c + DIM_ONE;
                r_d        = cur_r;
                row_base_d = cur_row_base;
            end
        end

        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);

        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_after;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            rows_q          <= '0;
            cols_q          <= '0;
            r_q             <= '0;
            c_q             <= '0;
            stride_q        <= '0;
            row_base_q      <= '0;
            mem_addr_q      <= '0;
            pending_q       <= 1'b0;
            pend_last_q     <= 1'b0;
            pend_last_col_q <= 1'b0;
            all_issued_q    <= 1'b0;
            cmd_ready_q     <= 1'b1;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
        end else begin
            state_q         <= state_d;
            rows_q          <= rows_d;
            cols_q          <= cols_d;
            r_q             <= r_d;
            c_q             <= c_d;
            stride_q        <= stride_d;
            row_base_q      <= row_base_d;
            mem_addr_q      <= mem_addr_d;
            pending_q       <= pending_d;
            pend_last_q     <= pend_last_d;
            pend_last_col_q <= pend_last_col_d;
            all_issued_q    <= all_issued_d;
            cmd_ready_q     <= cmd_ready_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
        end
    end

    // NOTE: FIFO storage is deliberately not reset; the pointers and count qualify every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {pend_last_q, pend_last_col_q, mem_rdata};
        end
    end

endmodule

// File: doc/weight_fetch_sequencer.md
# weight_fetch_sequencer

Tile-level read sequencer between the SPRAM weight memory controller and the systolic array weight loader. Accepts a tile descriptor (base, rows, cols, row stride), issues one read at a time on the controller's array read port, and buffers returned words in a small FIFO. It presents them as a valid/ready stream tagged with row-end and tile-end flags. Host traffic has priority inside the controller, so this block tolerates arbitrary read latency.

## Interface
- ADDR_WIDTH, 14, word address width (16K x 16-bit SPRAM)
- DATA_WIDTH, 16, weight word width
- DIM_WIDTH, 8, width of rows/cols fields
- FIFO_DEPTH, 4, output buffer entries (power of two, >= 2)

- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  descriptor valid
- cmd_ready  out  1  high only in IDLE
- cmd_base  in  ADDR_WIDTH  address of tile element (0,0)
- cmd_rows  in  DIM_WIDTH  row count
- cmd_cols  in  DIM_WIDTH  column count
- cmd_stride  in  ADDR_WIDTH  address delta between row starts
- mem_addr  out  ADDR_WIDTH  read address to controller
- mem_re  out  1  read request
- mem_rdata  in  DATA_WIDTH  read data
- mem_valid  in  1  read data valid (one-cycle pulse)
- w_data  out  DATA_WIDTH  FIFO head word
- w_valid  out  1  FIFO non-empty
- w_ready  in  1  consumer accepts
- w_last_col  out  1  head word is last column of its row
- w_last  out  1  head word is final word of tile
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at tile completion

## Operation
- Reset values: cmd_ready=1, mem_re=0, mem_addr=0, w_valid=0, w_data=0, w_last_col=0, w_last=0, busy=0, done=0. FIFO empty; no read outstanding.
- FSM states:
  - IDLE: cmd_valid&cmd_ready captures the descriptor, clears counters r=c=0, sets row_base=cmd_base. If rows==0 or cols==0, goes to DONE. Otherwise goes to FETCH.
  - FETCH: issues reads while elements remain. When the last read has returned, goes to DRAIN.
  - DRAIN: waits for the handshake w_valid&w_ready&w_last, then goes to DONE.
  - DONE: done=1 for one cycle, then goes to IDLE.
- Address generation is row-major, incremental, no multiplier:
  - addr = row_base + c.
  - At c==cols-1: c<=0, r<=r+1, row_base<=row_base+stride.
  - All sums are modulo 2^ADDR_WIDTH, so addresses wrap silently.
  - Overlapping strides (stride < cols) are legal.
- Read handshake:
  - At most one read is outstanding.
  - Issue only if FIFO occupancy + outstanding < FIFO_DEPTH.
  - mem_addr and the pending flag are registered. mem_addr is held stable for the entire pending period.
  - mem_re = pending & ~mem_valid (combinational drop), so the controller never sees a request in the cycle data returns. This prevents a duplicate access.
  - mem_valid with no read pending is ignored (stale or after reset).
- FIFO:
  - Each entry holds {last, last_col, data}. Flags are computed at issue time and carried with the pending read.
  - Push on mem_valid&pending. Pop on w_valid&w_ready. Simultaneous push and pop is legal at any occupancy, including full.
  - Outputs w_data, w_last_col and w_last are driven from the head entry. They are 0 when empty.
- Reset mid-tile: everything returns to reset values on the next edge. The FIFO is flushed. Any controller response still in flight is ignored because pending=0.
- cmd_valid outside IDLE is ignored (cmd_ready=0).

## Timing
- Cycle 0: cmd accepted.
- Cycle 1: FETCH, mem_re=1, mem_addr=base.
- Cycle 3: mem_valid pulse (idle controller). mem_re=0 in this cycle.
- Cycle 4: w_valid=1 with word 0; next mem_re=1 with the next address.
- Steady-state throughput with no host contention: 1 word / 3 cycles.
- Host contention may stretch any read to N cycles; mem_re and mem_addr stay constant throughout.
- done is asserted in the cycle after the w_last handshake. cmd_ready returns the cycle after done.
- Zero-size tile: accepted cycle 0, done=1 cycle 1, no mem_re, no w_valid.

## Test plan
- Tile rows=2, cols=3, base=0x0100, stride=4, w_ready=1 -> reads 0x100, 0x101, 0x102, 0x104, 0x105, 0x106 in order. w_last_col on words 3 and 6; w_last on word 6 only; single done pulse; mem_valid at cycle 3 per read.
- Backpressure: rows=1, cols=8, w_ready=0 -> exactly 4 reads issued, then mem_re stays 0. Raising w_ready drains all 8 words in order; FIFO never overflows.
- Wrap: base=0x3FFE, cols=4, rows=1 -> addresses 0x3FFE, 0x3FFF, 0x0000, 0x0001.
- Host contention: controller model delays mem_valid by 5 extra cycles -> mem_re and mem_addr held stable. No duplicate read observed; data order preserved.
- Zero size: rows=0, cols=5 -> done at cycle 1, no mem_re, cmd_ready back at cycle 2.
- Reset mid-tile: assert rst while a read is pending, then inject mem_valid 1 cycle after rst release -> all outputs at reset values, response ignored (w_valid stays 0). A new tile afterwards completes correctly.
